ov7670_stream_tx: RTL
=====================

# ov7670_stream_tx

- Transmitter counterpart of the OV7670 camera pixel-bus receiver.
- Consumes RGB565 pixels over a valid/ready stream and drives an OV7670-format parallel bus: `cam_PCLK`, `cam_VSYNC`, `cam_HREF` and `cam_D[7:0]`, two bytes per pixel.
- Used as the sensor stand-in in loopback and hardware self-test builds, so the capture and grayscale path runs without a physical camera.

## Interface
- `WIDTH`, 640, active pixels per line (≥1)
- `HEIGHT`, 480, active lines per frame (≥1)
- `H_BLANK`, 288, blank byte-times per line after active bytes (≥1)
- `VSYNC_LINES`, 3, lines with VSYNC high at frame start (≥1)
- `V_BACK`, 17, blank lines after VSYNC, before first active line (≥0)
- `V_FRONT`, 10, blank lines after last active line (≥0)
- `PCLK_HALF`, 3, sysclk cycles per PCLK half-period (≥1)
- `sysclk  in  1  ` the block's only clock
- `n_rst  in  1  ` reset, asynchronous, active-low
- `enable  in  1  ` run frames; sampled only at frame boundaries
- `s_valid  in  1  ` pixel available
- `s_data  in  16  ` RGB565 pixel
- `s_ready  out  1  ` pixel accepted this cycle
- `cam_PCLK  out  1  ` generated pixel clock
- `cam_VSYNC  out  1  ` frame sync, active high
- `cam_HREF  out  1  ` line-valid, active high
- `cam_D  out  8  ` byte data
- `busy  out  1  ` frame in progress
- `frame_done  out  1  ` one-cycle pulse at frame end
- `underrun  out  1  ` sticky: a pixel slot found `s_valid` low

## Operation
- **Derived constants.** `LINE_BYTES` = 2·WIDTH+H_BLANK. `FRAME_LINES` = VSYNC_LINES+V_BACK+HEIGHT+V_FRONT.
- **Counters.** Byte counter is $clog2(LINE_BYTES) bits and wraps at LINE_BYTES−1. Line counter is $clog2(FRAME_LINES) bits and wraps at FRAME_LINES−1.
- **PCLK.** Free-running from reset release: low PCLK_HALF cycles, then high PCLK_HALF cycles.
- **fall_tick.** The cycle that registers PCLK 1→0. All bus outputs update only on fall_tick, coincident with the falling edge. The receiver samples on the rising edge, so data is stable PCLK_HALF cycles before it.
- **States.**
  - IDLE: VSYNC/HREF/D = 0. On fall_tick with `enable`=1 → VSYNC.
  - VSYNC: VSYNC_LINES lines, VSYNC=1.
  - VBACK: V_BACK lines, skipped if 0.
  - ACTIVE: HEIGHT lines.
  - VFRONT: V_FRONT lines, skipped if 0.
  - End of frame: `frame_done` pulses on the fall_tick ending the last byte of the frame. Next state is VSYNC if `enable`=1, else IDLE.
- **Line timing.** Every line, in every state, lasts LINE_BYTES byte-times.
- **ACTIVE line bytes.** Bytes 0..2·WIDTH−1 have HREF=1; the remaining H_BLANK bytes have HREF=0 and D=0.
- **Byte packing.** Even byte = {R[4:0],G[5:3]}. Odd byte = {G[2:0],B[4:0]}, taken from the pixel held since the even byte.
- **Handshake.**
  - `s_ready` = fall_tick & ACTIVE & even byte slot & `s_valid`. Combinational, at most one cycle per pixel.
  - Data is captured when `s_ready`=1.
  - If `s_valid`=0 at that slot: send pixel 0x0000 and set `underrun`. No pixel is consumed late.
- **underrun clear.** Cleared on the fall_tick entering VSYNC.
- **busy.** 1 in every state except IDLE.
- **enable deasserted mid-frame.** The frame completes, then the block returns to IDLE.
- **Reset mid-operation.** All registers return to reset values immediately; no partial-frame recovery.

## Timing
- **Reset values.** cam_PCLK=0, cam_VSYNC=0, cam_HREF=0, cam_D=0, busy=0, frame_done=0, underrun=0, s_ready=0. State IDLE, counters 0.
- **Start latency.** VSYNC rises on the first fall_tick with `enable`=1, at most 2·PCLK_HALF cycles after `enable` rises.
- **Frame period.** LINE_BYTES·FRAME_LINES·2·PCLK_HALF sysclk cycles. Back-to-back frames have no gap.
- **Pixel to bus.** Pixel accepted on fall_tick N appears on cam_D in cycle N+1, with its second byte 2·PCLK_HALF cycles later.

## Structure
- **Package `ov7670_tx_pkg`:**
  - state enum `tx_state_t`
  - functions `rgb565_hi` / `rgb565_lo`, returning the byte split
- **Sub-module `ov7670_pclk_gen`.** Parameter PCLK_HALF; outputs `pclk`, `fall_tick`, `rise_tick`.
- **Top level.** Holds the state machine, both counters and the pixel hold register.
- **Elaboration check.** Assert at elaboration that the parameter minima hold.

## Test plan
Common parameters: WIDTH=4, HEIGHT=2, H_BLANK=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, PCLK_HALF=2, so frame = 50 byte-times = 200 cycles.

1. **Reset.** Hold `n_rst`=0 → all outputs 0. After release, cam_PCLK has period 4, duty 50%, with `enable`=0 → VSYNC/HREF/D stay 0.
2. **Single frame.** Pixels F800, 07E0, 001F, FFFF per line, `s_valid` held high → checks:
   - VSYNC high 10 byte-times
   - per line: bytes F8 00 07 E0 00 1F FF FF with HREF high 8 byte-times, then 2 blank
   - 2 active lines, 8 `s_ready` pulses
   - frame_done exactly 200 cycles after VSYNC rise
3. **Underrun.** `s_valid`=0 at pixel 2 of line 0 → bytes 00 00 in that slot, underrun=1, remaining pixels unshifted. Underrun=0 after the next VSYNC rise.
4. **Enable drop.** `enable` deasserted during line 3 → frame finishes, frame_done pulses, busy=0, no further VSYNC.
5. **Reset mid-frame.** `n_rst` pulsed during an active line → outputs 0 in the same cycle, s_ready=0. With `enable`=1 after release, the next frame starts with a full VSYNC.
6. **Back-to-back.** `enable` held for 3 frames → VSYNC rises on the fall_tick after each frame_done, frame_done spacing exactly 200 cycles.

Source files
------------

// File: rtl/ov7670_tx_pkg.sv
// Shared types and helpers for the OV7670-format transmitter.
// RGB565 pixels leave the block as two bytes, high byte first.
package ov7670_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } tx_state_t;

    function automatic logic [7:0] rgb565_hi(input logic [15:0] px);
        return {px[15:11], px[10:8]};
    endfunction

    function automatic logic [7:0] rgb565_lo(input logic [15:0] px);
        return {px[7:5], px[4:0]};
    endfunction

endpackage

// File: rtl/ov7670_stream_tx_if.sv
// Valid/ready pixel stream feeding the OV7670 transmitter.
interface ov7670_stream_tx_if;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ov7670_pclk_gen.sv
// Free-running pixel clock: PCLK_HALF cycles low, PCLK_HALF high.
// Ticks flag the sysclk cycle that registers each PCLK edge.
module ov7670_pclk_gen #(
    parameter int PCLK_HALF = 3
) (
    input  logic sysclk,
    input  logic n_rst,
    output logic pclk,
    output logic fall_tick,
    output logic rise_tick
);
    localparam int CW = (PCLK_HALF > 1) ? $clog2(PCLK_HALF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PCLK_HALF - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pclk_q, pclk_d;
    logic          wrap;

    assign wrap = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        pclk_d = wrap ? ~pclk_q : pclk_q;
    end

    always_ff @(posedge sysclk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q  <= '0;
            pclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pclk_q <= pclk_d;
        end
    end

    assign pclk      = pclk_q;
    assign fall_tick = wrap & pclk_q;
    assign rise_tick = wrap & ~pclk_q;
endmodule

// File: rtl/ov7670_stream_tx.sv
// RGB565 stream to OV7670 parallel bus (PCLK/VSYNC/HREF/D).
// Bus registers advance only on the PCLK falling edge.
module ov7670_stream_tx
    import ov7670_tx_pkg::*;
#(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int H_BLANK     = 288,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int PCLK_HALF   = 3
) (
    input  logic               sysclk,
    input  logic               n_rst,
    input  logic               enable,
    ov7670_stream_tx_if.slave  s,
    output logic               cam_PCLK,
    output logic               cam_VSYNC,
    output logic               cam_HREF,
    output logic [7:0]         cam_D,
    output logic               busy,
    output logic               frame_done,
    output logic               underrun
);
    localparam int LINE_BYTES  = 2 * WIDTH + H_BLANK;
    localparam int FRAME_LINES = VSYNC_LINES + V_BACK + HEIGHT + V_FRONT;
    localparam int BW = $clog2(LINE_BYTES);
    localparam int LW = $clog2(FRAME_LINES);

    localparam logic [BW-1:0] LAST_BYTE = BW'(LINE_BYTES - 1);
    localparam logic [BW-1:0] ACT_BYTES = BW'(2 * WIDTH);
    localparam logic [LW-1:0] L_VS_END  = LW'(VSYNC_LINES - 1);
    localparam logic [LW-1:0] L_VB_END  = LW'(VSYNC_LINES + V_BACK - 1);
    localparam logic [LW-1:0] L_ACT_END = LW'(VSYNC_LINES + V_BACK + HEIGHT - 1);
    localparam logic [LW-1:0] L_LAST    = LW'(FRAME_LINES - 1);

    if (WIDTH < 1 || HEIGHT < 1 || H_BLANK < 1 || VSYNC_LINES < 1 ||
        V_BACK < 0 || V_FRONT < 0 || PCLK_HALF < 1) begin : g_bad_param
        $error("ov7670_stream_tx: parameter below its minimum");
    end

    logic fall_tick;
    logic pclk_rise_unused;

    ov7670_pclk_gen #(.PCLK_HALF(PCLK_HALF)) u_pclk (
        .sysclk    (sysclk),
        .n_rst     (n_rst),
        .pclk      (cam_PCLK),
        .fall_tick (fall_tick),
        .rise_tick (pclk_rise_unused)
    );

    tx_state_t     state_q, state_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [LW-1:0] line_q, line_d;
    logic [15:0]   pix_q, pix_d;
    logic          under_q, under_d;
    logic          vs_q, vs_d;
    logic          href_q, href_d;
    logic [7:0]    d_q, d_d;
    logic          done_q, done_d;
    logic          eof;
    logic          slot;

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        line_d    = line_q;
        pix_d     = pix_q;
        under_d   = under_q;
        vs_d      = vs_q;
        href_d    = href_q;
        d_d       = d_q;
        done_d    = 1'b0;
        eof       = 1'b0;
        slot      = 1'b0;
        s.s_ready = 1'b0;

        if (fall_tick) begin
            if (state_q == S_IDLE) begin
                if (enable) begin
                    state_d = S_VSYNC;
                    byte_d  = '0;
                    line_d  = '0;
                end
            end else if (byte_q == LAST_BYTE) begin
                byte_d = '0;
                line_d = line_q + LW'(1);
                unique case (state_q)
                    S_VSYNC:
                        if (line_q == L_VS_END)
                            state_d = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
                    S_VBACK:
                        if (line_q == L_VB_END) state_d = S_ACTIVE;
                    S_ACTIVE:
                        if (line_q == L_ACT_END) begin
                            if (V_FRONT > 0) state_d = S_VFRONT;
                            else             eof = 1'b1;
                        end
                    S_VFRONT:
                        if (line_q == L_LAST) eof = 1'b1;
                    default: ;
                endcase
                if (eof) begin
                    state_d = enable ? S_VSYNC : S_IDLE;
                    line_d  = '0;
                    done_d  = 1'b1;
                end
            end else begin
                byte_d = byte_q + BW'(1);
            end

            // Outputs describe the byte-time that starts at this edge
            if (state_q != S_VSYNC && state_d == S_VSYNC) under_d = 1'b0;
            slot   = (state_d == S_ACTIVE) && (byte_d < ACT_BYTES);
            vs_d   = (state_d == S_VSYNC);
            href_d = slot;
            d_d    = 8'h00;
            if (slot && !byte_d[0]) begin
                s.s_ready = s.s_valid;
                pix_d     = s.s_valid ? s.s_data : 16'h0000;
                under_d   = under_q | ~s.s_valid;
                d_d       = rgb565_hi(pix_d);
            end else if (slot) begin
                d_d = rgb565_lo(pix_q);
            end
        end
    end

    always_ff @(posedge sysclk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            byte_q  <= '0;
            line_q  <= '0;
            pix_q   <= '0;
            under_q <= 1'b0;
            vs_q    <= 1'b0;
            href_q  <= 1'b0;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            line_q  <= line_d;
            pix_q   <= pix_d;
            under_q <= under_d;
            vs_q    <= vs_d;
            href_q  <= href_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

    assign cam_VSYNC  = vs_q;
    assign cam_HREF   = href_q;
    assign cam_D      = d_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;
    assign underrun   = under_q;
endmodule
